// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared pipeline definitions.
//   ctrl_t      : packed group of the decoder control bits carried down the pipe
//   RES_*       : ResultSrc encodings (ALU result, memory read data, PC+4)
//   CTRL_BUBBLE : all-zero control word; a bubble can never write, branch or jump
package pipeline_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_execute_reg_if.sv
// decode_execute_reg_if -- decode-to-execute pipeline register bus.
//   Stage controls : StallE, FlushE
//   Decode side    : ValidD, control bits, Funct3D, operands, PC, immediate, reg addresses
//   Execute side   : registered copies of the above plus BubbleCount
//   master drives the D side and controls; slave (the register) drives the E side.
interface decode_execute_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  StallE;
    logic                  FlushE;
    logic                  ValidD,     ValidE;
    logic                  RegWriteD,  RegWriteE;
    logic                  MemWriteD,  MemWriteE;
    logic                  JumpD,      JumpE;
    logic                  BranchD,    BranchE;
    logic                  ALUSrcD,    ALUSrcE;
    logic [1:0]            ResultSrcD, ResultSrcE;
    logic [3:0]            ALUControlD, ALUControlE;
    logic [2:0]            Funct3D,    Funct3E;
    logic [DATA_WIDTH-1:0] RD1D,       RD1E;
    logic [DATA_WIDTH-1:0] RD2D,       RD2E;
    logic [DATA_WIDTH-1:0] PCD,        PCE;
    logic [DATA_WIDTH-1:0] ImmExtD,    ImmExtE;
    logic [DATA_WIDTH-1:0] PCPlus4D,   PCPlus4E;
    logic [4:0]            Rs1D,       Rs1E;
    logic [4:0]            Rs2D,       Rs2E;
    logic [4:0]            RdD,        RdE;
    logic [CNT_WIDTH-1:0]  BubbleCount;

    modport master (
        output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
               Rs1E, Rs2E, RdE, BubbleCount
    );

    modport slave (
        input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, Funct3D, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
               Rs1E, Rs2E, RdE, BubbleCount
    );
endinterface

// File: rtl/pipe_reg.sv
// pipe_reg -- generic pipeline register.
//   clk, rst : clock and synchronous active-high reset
//   en       : load d when high (low holds)
//   clr      : load zero; wins over en
//   d, q     : WIDTH-bit data in / registered data out
// Priority on each rising edge: rst > clr > en > hold.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/decode_execute_reg.sv
// decode_execute_reg -- decode/execute pipeline boundary register.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset, clears every output
//   bus : decode_execute_reg_if slave -- D-side inputs, StallE/FlushE,
//         E-side registered outputs and BubbleCount
// Edge priority: rst > FlushE > StallE > capture. A bubble is any edge that
// loads ValidE=0 outside reset; BubbleCount counts them and saturates.
module decode_execute_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_execute_reg_if.slave  bus
);
    localparam int DATA_W = 5 * DATA_WIDTH + 3 * 5 + 3;

    ctrl_t              ctrl_d;
    ctrl_t              ctrl_gated;
    ctrl_t              ctrl_q;
    logic [DATA_W-1:0]  data_d;
    logic [DATA_W-1:0]  data_q;
    logic               valid_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    logic               capture;
    logic               bubble;

    assign capture = !bus.StallE && !bus.FlushE;

    // Flush always inserts a bubble (even when stalled); a capture of an
    // invalid decode slot does too. Reset edges never count.
    assign bubble = bus.FlushE || (!bus.StallE && !bus.ValidD);

    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = bus.RegWriteD;
        ctrl_d.result_src  = bus.ResultSrcD;
        ctrl_d.mem_write   = bus.MemWriteD;
        ctrl_d.jump        = bus.JumpD;
        ctrl_d.branch      = bus.BranchD;
        ctrl_d.alu_control = bus.ALUControlD;
        ctrl_d.alu_src     = bus.ALUSrcD;
    end

    // An invalid instruction must never carry live control bits into execute.
    assign ctrl_gated = bus.ValidD ? ctrl_d : CTRL_BUBBLE;

    assign data_d = {bus.PCD, bus.PCPlus4D, bus.ImmExtD, bus.RD1D, bus.RD2D,
                     bus.Rs1D, bus.Rs2D, bus.RdD, bus.Funct3D};

    pipe_reg #(.WIDTH($bits(ctrl_t))) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (!bus.StallE),
        .clr (bus.FlushE),
        .d   (ctrl_gated),
        .q   (ctrl_q)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (!bus.StallE),
        .clr (bus.FlushE),
        .d   (data_d),
        .q   (data_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (bus.FlushE) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg <= bus.ValidD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (bubble && (count_reg != {CNT_WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.ValidE      = valid_reg;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.ALUControlE = ctrl_q.alu_control;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign {bus.PCE, bus.PCPlus4E, bus.ImmExtE, bus.RD1E, bus.RD2E,
            bus.Rs1E, bus.Rs2E, bus.RdE, bus.Funct3E} = data_q;
    assign bus.BubbleCount = count_reg;
endmodule

// File: doc/decode_execute_reg.md
DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of the register-file operand, PC and immediate paths.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the bubble counter.
REQ-003 The block SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-004 Ports: StallE  in  1  hold the stage contents; FlushE  in  1  replace the stage contents with a bubble.
REQ-005 Ports: ValidD  in  1  decode-stage instruction valid; ValidE  out  1  execute-stage instruction valid.
REQ-006 Ports: RegWriteD/E, MemWriteD/E, JumpD/E, BranchD/E, ALUSrcD/E  in/out  1 each  decoder control bits.
REQ-007 Ports: ResultSrcD/E  in/out  2  result select, where 00 = ALU, 01 = memory, 10 = PC+4; ALUControlD/E  in/out  4  ALU operation.
REQ-008 Ports: Funct3D/E  in/out  3  branch and load/store subtype.
REQ-009 Ports: RD1D/E, RD2D/E, PCD/E, ImmExtD/E, PCPlus4D/E  in/out  DATA_WIDTH each  operands, PC and immediate.
REQ-010 Ports: Rs1D/E, Rs2D/E, RdD/E  in/out  5 each  register addresses, forwarded to the hazard unit.
REQ-011 Ports: BubbleCount  out  CNT_WIDTH  number of bubbles inserted since reset.

Function
REQ-012 Every E output SHALL be a registered copy of its D input with exactly one clk cycle of latency; no D-to-E combinational path.
REQ-013 Per rising edge, the priority SHALL be rst > FlushE > StallE > capture.
REQ-014 Capture (StallE=0, FlushE=0): all E outputs SHALL load their D inputs, including ValidE <= ValidD.
REQ-015 Stall (StallE=1, FlushE=0): all E outputs and BubbleCount SHALL hold their values.
REQ-016 Flush (FlushE=1, with StallE either value): ValidE, RegWriteE, MemWriteE, JumpE and BranchE SHALL be 0; ResultSrcE and ALUControlE SHALL be 0; all data and address outputs SHALL be 0.
REQ-017 A bubble SHALL be inserted whenever the register loads ValidE=0, i.e. on a flush, or on a capture with ValidD=0.
REQ-018 BubbleCount SHALL increment by 1 on each bubble insertion.
REQ-019 BubbleCount SHALL saturate at all-ones and SHALL NOT wrap.
REQ-020 BubbleCount SHALL NOT change on a stall cycle or on a capture with ValidD=1.
REQ-021 When ValidE=0, all E control outputs SHALL be 0, so that a bubble can never write the register file or memory, branch, or jump.
REQ-022 A capture with ValidD=0 SHALL force the E control outputs to 0 regardless of the D control inputs.
REQ-023 Simultaneous StallE and FlushE SHALL be treated as a flush, with exactly one count increment.

Reset
REQ-024 With rst=1 at a rising edge, every output, including ValidE and BubbleCount, SHALL be 0 at the next edge, regardless of StallE and FlushE.
REQ-025 A reset that arrives during a stall SHALL discard the held instruction.
REQ-026 The first capture after rst deasserts SHALL behave as a normal capture.
REQ-027 Reset cycles SHALL NOT increment BubbleCount.

Structure
REQ-028 A shared package pipeline_pkg SHALL hold the ctrl_t packed struct, which groups RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl and ALUSrc.
REQ-029 pipeline_pkg SHALL hold the ResultSrc encodings RES_ALU, RES_MEM and RES_PC4, and the constant CTRL_BUBBLE, which is all zeros.
REQ-030 The block SHALL use one sub-module, pipe_reg: a parameterised-width register with synchronous reset, enable and clear, instantiated for the ctrl_t group and for the data group.
REQ-031 The bubble counter and the valid gating SHALL reside in the top level.

Verification
REQ-032 Capture: ValidD=1, RegWriteD=1, ALUControlD=4'b0010, RD1D=32'h0000_0005 -> one edge later ValidE=1, RegWriteE=1, ALUControlE=4'b0010, RD1E=5, and BubbleCount is unchanged.
REQ-033 Stall: after a capture with PCD=32'h100, hold StallE=1 for 3 cycles while PCD changes to 32'h104 -> PCE stays 32'h100 for all 3 cycles, then becomes 32'h104 on the first edge with StallE=0.
REQ-034 Flush over stall: StallE=1 and FlushE=1 with MemWriteD=1 -> next cycle ValidE=0, MemWriteE=0, all data outputs 0, and BubbleCount increased by exactly 1.
REQ-035 Invalid capture: ValidD=0 with JumpD=1 and BranchD=1 -> next cycle JumpE=0, BranchE=0, ValidE=0, and BubbleCount increased by 1.
REQ-036 Saturation: with CNT_WIDTH=4, hold FlushE=1 for 20 cycles -> BubbleCount reaches 4'hF and stays at 4'hF.
REQ-037 Mid-stall reset: with ValidE=1 held by StallE=1, assert rst for 1 cycle -> all outputs 0 at the next edge; then deassert rst with ValidD=1 -> ValidE=1 one cycle later.
